// File: rtl/pll_lock_supervisor.sv
// Power-up and fault sequencer for the ECP5 EHXPLLL. Clocked by the free-running
// reference clock so it keeps working while the PLL output is absent or unlocked.
module pll_lock_supervisor #(
  parameter int RST_PULSE    = 4,
  parameter int LOCK_TIMEOUT = 250000,
  parameter int LOCK_STABLE  = 2500,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state_dbg
);

  localparam int PW = $clog2(RST_PULSE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);

  localparam logic [PW-1:0] P_LAST = PW'(RST_PULSE - 1);
  localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [3:0]    R_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [3:0]    retry_n;
  logic [7:0]    loss_n;
  logic          lock_meta, lock_s;
  logic          take_timeout;

  // pll_locked is asynchronous to clkin; only lock_s is used for decisions.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state     <= RESET_PLL;
      pcnt      <= '0;
      tcnt      <= '0;
      scnt      <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_n;
      pcnt      <= pcnt_n;
      tcnt      <= tcnt_n;
      scnt      <= scnt_n;
      retry_cnt <= retry_n;
      loss_cnt  <= loss_n;
      // Outputs decode the next state so they move on the same edge as the state.
      pll_rst   <= (state_n == RESET_PLL);
      sys_rst   <= (state_n != RUN);
      ready     <= (state_n == RUN);
      fail      <= (state_n == FAIL);
    end
  end

  always_comb begin
    state_n      = state;
    pcnt_n       = pcnt;
    tcnt_n       = tcnt;
    scnt_n       = scnt;
    retry_n      = retry_cnt;
    loss_n       = loss_cnt;
    take_timeout = 1'b0;
    if (restart) begin
      state_n = RESET_PLL;
      pcnt_n  = '0;
      retry_n = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (pcnt >= P_LAST) begin
            state_n = WAIT_LOCK;
            pcnt_n  = '0;
            tcnt_n  = '0;
          end else begin
            pcnt_n = pcnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (tcnt >= T_LAST) begin
            take_timeout = 1'b1;
          end else begin
            tcnt_n = tcnt + 1'b1;
            if (lock_s) begin
              state_n = STABLE;
              scnt_n  = SW'(1);
            end
          end
        end
        STABLE: begin
          // A completed stability window beats a coincident timeout.
          if (lock_s && (scnt >= S_LAST)) begin
            state_n = RUN;
          end else if (tcnt >= T_LAST) begin
            take_timeout = 1'b1;
          end else begin
            tcnt_n = tcnt + 1'b1;
            if (lock_s) scnt_n = scnt + 1'b1;
            else        state_n = WAIT_LOCK;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_n = RESET_PLL;
            pcnt_n  = '0;
            retry_n = '0;
            if (loss_cnt != 8'hff) loss_n = loss_cnt + 8'd1;
          end
        end
        FAIL: ;
        default: state_n = RESET_PLL;
      endcase
      if (take_timeout) begin
        if (retry_cnt >= R_MAX) begin
          state_n = FAIL;
        end else begin
          state_n = RESET_PLL;
          pcnt_n  = '0;
          retry_n = retry_cnt + 4'd1;
        end
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters
// (pulse 4, timeout 100, stable 8, 2 retries).
module tb_pll_lock_supervisor;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  logic       clkin = 1'b0;
  logic       resetn;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;

  pll_lock_supervisor #(
    .RST_PULSE   (4),
    .LOCK_TIMEOUT(100),
    .LOCK_STABLE (8),
    .MAX_RETRIES (2)
  ) dut (
    .clkin     (clkin),
    .resetn    (resetn),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clkin = ~clkin;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // One clkin cycle: inputs set before this are taken at the posedge, outputs are
  // observed at the following negedge.
  task automatic cyc();
    @(posedge clkin);
    @(negedge clkin);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
  endtask

  // Number of consecutive observed cycles with pll_rst == val (current one included).
  task automatic count_run(input logic val, input int budget, output int n);
    n = 0;
    while (pll_rst === val && fail !== 1'b1 && n < budget) begin
      n++;
      cyc();
    end
  endtask

  // Cycles until ready rises; -1 when the budget expires.
  task automatic wait_ready(input int budget, output int n, output bit early);
    n = 0;
    early = 1'b0;
    while (ready !== 1'b1 && n < budget) begin
      if (sys_rst !== 1'b1) early = 1'b1;
      cyc();
      n++;
    end
    if (ready !== 1'b1) n = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    @(negedge clkin);
    cyc();
    checks++; if (pll_rst !== 1'b1)   begin errors++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    checks++; if (sys_rst !== 1'b1)   begin errors++; $display("FAIL reset_sys_rst: got %b want 1", sys_rst); end
    checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (fail !== 1'b0)      begin errors++; $display("FAIL reset_fail: got %b want 0", fail); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
    checks++; if (loss_cnt !== 8'd0)  begin errors++; $display("FAIL reset_loss: got %0d want 0", loss_cnt); end
    checks++; if (state_dbg !== S_RESET) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_RESET); end
  endtask

  task automatic test_first_lock();
    int  n;
    bit  early;
    resetn = 1'b1;
    count_run(1'b1, 20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL first_pulse_len: got %0d want 4", n); end
    checks++; if (state_dbg !== S_WAIT) begin errors++; $display("FAIL first_wait_state: got %0d want %0d", state_dbg, S_WAIT); end
    repeat (20) cyc();
    pll_locked = 1'b1;
    // 2 synchroniser cycles + 8 stable samples
    wait_ready(40, n, early);
    checks++; if (n !== 10) begin errors++; $display("FAIL first_lock_latency: got %0d want 10", n); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL first_sys_rst_early: got %b want 0", early); end
    checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL first_sys_rst: got %b want 0", sys_rst); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL first_retry: got %0d want 0", retry_cnt); end
    checks++; if (state_dbg !== S_RUN) begin errors++; $display("FAIL first_run_state: got %0d want %0d", state_dbg, S_RUN); end
  endtask

  task automatic test_lock_loss();
    int n;
    bit early;
    pll_locked = 1'b0;
    cyc(); cyc();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss_ready_held: got %b want 1", ready); end
    cyc();
    pll_locked = 1'b1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL loss_ready_drop: got %b want 0", ready); end
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL loss_sys_rst: got %b want 1", sys_rst); end
    checks++; if (loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_cnt_1: got %0d want 1", loss_cnt); end
    count_run(1'b1, 20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL loss_pulse_len: got %0d want 4", n); end
    wait_ready(40, n, early);
    checks++; if (n !== 8) begin errors++; $display("FAIL loss_relock_latency: got %0d want 8", n); end
    checks++; if (loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_cnt_after: got %0d want 1", loss_cnt); end
  endtask

  task automatic test_timeout_fail();
    int hi, lo;
    pll_locked = 1'b0;
    pulse_restart();
    checks++; if (loss_cnt !== 8'd1) begin errors++; $display("FAIL tmo_restart_loss: got %0d want 1", loss_cnt); end
    for (int a = 0; a < 3; a++) begin
      count_run(1'b1, 20, hi);
      checks++; if (hi !== 4) begin errors++; $display("FAIL tmo_pulse_len[%0d]: got %0d want 4", a, hi); end
      count_run(1'b0, 200, lo);
      checks++; if (lo !== 100) begin errors++; $display("FAIL tmo_wait_len[%0d]: got %0d want 100", a, lo); end
      if (a < 2) begin
        checks++; if (retry_cnt !== 4'(a + 1)) begin errors++; $display("FAIL tmo_retry[%0d]: got %0d want %0d", a, retry_cnt, a + 1); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL tmo_fail_early[%0d]: got %b want 0", a, fail); end
      end
    end
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL tmo_fail: got %b want 1", fail); end
    checks++; if (retry_cnt !== 4'd2) begin errors++; $display("FAIL tmo_fail_retry: got %0d want 2", retry_cnt); end
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL tmo_fail_sys_rst: got %b want 1", sys_rst); end
    checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL tmo_fail_pll_rst: got %b want 0", pll_rst); end
    pll_locked = 1'b1;
    repeat (30) cyc();
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL tmo_fail_sticky: got %b want 1", fail); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL tmo_fail_ready: got %b want 0", ready); end
    checks++; if (state_dbg !== S_FAIL) begin errors++; $display("FAIL tmo_fail_state: got %0d want %0d", state_dbg, S_FAIL); end
  endtask

  task automatic test_restart_fail();
    int n;
    bit early;
    pulse_restart();
    checks++; if (state_dbg !== S_RESET) begin errors++; $display("FAIL rf_state: got %0d want %0d", state_dbg, S_RESET); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL rf_fail: got %b want 0", fail); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL rf_retry: got %0d want 0", retry_cnt); end
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL rf_pll_rst: got %b want 1", pll_rst); end
    checks++; if (loss_cnt !== 8'd1) begin errors++; $display("FAIL rf_loss: got %0d want 1", loss_cnt); end
    // 4 pulse + 1 wait edge + 7 more stable samples
    wait_ready(60, n, early);
    checks++; if (n !== 12) begin errors++; $display("FAIL rf_run_latency: got %0d want 12", n); end
  endtask

  task automatic test_dropout();
    int  n, found, i;
    bit  seen_ready;
    // Dropout right after entering WAIT_LOCK: RUN only after 8 fresh synced-high samples.
    pll_locked = 1'b0;
    pulse_restart();
    count_run(1'b1, 20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL drop_a_pulse: got %0d want 4", n); end
    found = -1;
    for (int k = 0; k < 40; k++) begin
      pll_locked = (k < 5) || (k >= 6);
      cyc();
      if (ready === 1'b1 && found < 0) found = k + 1;
    end
    checks++; if (found !== 16) begin errors++; $display("FAIL drop_a_run_cycle: got %0d want 16", found); end
    // Same pattern starting 90 cycles into the wait: the unreset timeout fires first.
    pll_locked = 1'b0;
    pulse_restart();
    count_run(1'b1, 20, n);
    found = -1;
    seen_ready = 1'b0;
    i = 0;
    while (found < 0 && i < 150) begin
      pll_locked = ((i >= 90) && (i < 95)) || (i >= 96);
      cyc();
      i++;
      if (ready === 1'b1) seen_ready = 1'b1;
      if (pll_rst === 1'b1) found = i;
    end
    checks++; if (found !== 100) begin errors++; $display("FAIL drop_b_timeout_cycle: got %0d want 100", found); end
    checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL drop_b_ready_seen: got %b want 0", seen_ready); end
    checks++; if (retry_cnt !== 4'd1) begin errors++; $display("FAIL drop_b_retry: got %0d want 1", retry_cnt); end
  endtask

  task automatic test_restart_stable();
    int n;
    bit early;
    repeat (6) cyc();
    checks++; if (state_dbg !== S_STABLE) begin errors++; $display("FAIL rs_pre_state: got %0d want %0d", state_dbg, S_STABLE); end
    checks++; if (retry_cnt !== 4'd1) begin errors++; $display("FAIL rs_pre_retry: got %0d want 1", retry_cnt); end
    pulse_restart();
    checks++; if (state_dbg !== S_RESET) begin errors++; $display("FAIL rs_state: got %0d want %0d", state_dbg, S_RESET); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL rs_retry: got %0d want 0", retry_cnt); end
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL rs_pll_rst: got %b want 1", pll_rst); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL rs_fail: got %b want 0", fail); end
    checks++; if (loss_cnt !== 8'd1) begin errors++; $display("FAIL rs_loss: got %0d want 1", loss_cnt); end
    wait_ready(60, n, early);
    checks++; if (n !== 12) begin errors++; $display("FAIL rs_run_latency: got %0d want 12", n); end
  endtask

  task automatic test_loss_saturation();
    int          n;
    bit          early;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_v;
    for (int k = 1; k <= 300; k++) exp_q.push_back((k + 1 > 255) ? 8'd255 : 8'(k + 1));
    for (int k = 1; k <= 300; k++) begin
      pll_locked = 1'b0;
      repeat (3) cyc();
      pll_locked = 1'b1;
      exp_v = exp_q.pop_front();
      checks++; if (loss_cnt !== exp_v) begin errors++; $display("FAIL sat_loss[%0d]: got %0d want %0d", k, loss_cnt, exp_v); end
      wait_ready(40, n, early);
      checks++; if (n < 0) begin errors++; $display("FAIL sat_relock[%0d]: ready not reached within 40 cycles", k); end
    end
  endtask

  task automatic test_async_reset();
    pll_locked = 1'b0;
    pulse_restart();
    repeat (14) cyc();
    checks++; if (state_dbg !== S_WAIT) begin errors++; $display("FAIL ar_pre_state: got %0d want %0d", state_dbg, S_WAIT); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (pll_rst !== 1'b1)   begin errors++; $display("FAIL ar_pll_rst: got %b want 1", pll_rst); end
    checks++; if (sys_rst !== 1'b1)   begin errors++; $display("FAIL ar_sys_rst: got %b want 1", sys_rst); end
    checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL ar_ready: got %b want 0", ready); end
    checks++; if (fail !== 1'b0)      begin errors++; $display("FAIL ar_fail: got %b want 0", fail); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL ar_retry: got %0d want 0", retry_cnt); end
    checks++; if (loss_cnt !== 8'd0)  begin errors++; $display("FAIL ar_loss: got %0d want 0", loss_cnt); end
    checks++; if (state_dbg !== S_RESET) begin errors++; $display("FAIL ar_state: got %0d want %0d", state_dbg, S_RESET); end
    @(negedge clkin);
    resetn = 1'b1;
    repeat (3) cyc();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_lock();
    test_lock_loss();
    test_timeout_fail();
    test_restart_fail();
    test_dropout();
    test_restart_stable();
    test_loss_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
